// File: rtl/arith_pipe_pkg.sv
// Shared definitions for the segmented adder pipeline: operand-select
// encodings and the segment-count derivation.
package arith_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUBN = 2'b01,
    OP_ZERO = 2'b10,
    OP_ONES = 2'b11
  } op_e;

  // Number of SEG-bit segments in a WIDTH-bit operand.
  function automatic int calc_nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/arith_seg.sv
// One SEG-bit registered adder stage of the segmented pipeline. The carry
// out is registered so the next segment sees it one cycle later.
module arith_seg
  import arith_pipe_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] y_seg,
  input  logic           c_in,
  input  logic           in_valid,
  input  logic           advance,
  output logic [SEG-1:0] sum_seg,
  output logic           c_out,
  output logic           out_valid
);

  // Register the segment sum, its carry and the stage valid bit on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_seg   <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      {c_out, sum_seg} <= {1'b0, a_seg} + {1'b0, y_seg} + {{SEG{1'b0}}, c_in};
      out_valid        <= in_valid;
    end
  end

endmodule

// File: rtl/arith_pipe.sv
// Segmented, globally stalled adder pipeline: {cout,d} = a + Y + cin with
// Y selected from b by sel. Segment k is added in stage k; higher operand
// segments are skewed in, lower sum segments are deskewed out.
// Optional feature: define ARITH_PIPE_SAT_EN to saturate d on signed overflow.
module arith_pipe
  import arith_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG);

  logic             advance;
  logic [WIDTH-1:0] y_sel;
  logic [WIDTH-1:0] d_wrap;
  logic [SEG-1:0]   a_use   [NSEG];
  logic [SEG-1:0]   y_use   [NSEG];
  logic [SEG-1:0]   sum_seg [NSEG];
  logic             c_use   [NSEG];
  logic             v_use   [NSEG];
  logic             c_out   [NSEG];
  logic             v_out   [NSEG];
  logic             a_msb_reg;
  logic             y_msb_reg;

  // The whole pipeline moves together unless a held result is refused.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Pick the second operand before stage 0.
  always_comb begin
    y_sel = b;
    case (op_e'(sel))
      OP_ADD:  y_sel = b;
      OP_SUBN: y_sel = ~b;
      OP_ZERO: y_sel = '0;
      OP_ONES: y_sel = '1;
      default: y_sel = b;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      if (gi == 0) begin : g_first
        assign a_use[gi] = a[SEG-1:0];
        assign y_use[gi] = y_sel[SEG-1:0];
        assign c_use[gi] = cin;
        assign v_use[gi] = in_valid;
      end else begin : g_skew
        logic [SEG-1:0] a_sk_reg [gi];
        logic [SEG-1:0] y_sk_reg [gi];

        // Delay operand segment gi by gi cycles so it meets its carry.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < gi; i++) begin
              a_sk_reg[i] <= '0;
              y_sk_reg[i] <= '0;
            end
          end else if (advance) begin
            a_sk_reg[0] <= a[gi*SEG +: SEG];
            y_sk_reg[0] <= y_sel[gi*SEG +: SEG];
            for (int i = 1; i < gi; i++) begin
              a_sk_reg[i] <= a_sk_reg[i-1];
              y_sk_reg[i] <= y_sk_reg[i-1];
            end
          end
        end

        assign a_use[gi] = a_sk_reg[gi-1];
        assign y_use[gi] = y_sk_reg[gi-1];
        assign c_use[gi] = c_out[gi-1];
        assign v_use[gi] = v_out[gi-1];
      end

      arith_seg #(.SEG(SEG)) u_seg (
        .clk       (clk),
        .rst       (rst),
        .a_seg     (a_use[gi]),
        .y_seg     (y_use[gi]),
        .c_in      (c_use[gi]),
        .in_valid  (v_use[gi]),
        .advance   (advance),
        .sum_seg   (sum_seg[gi]),
        .c_out     (c_out[gi]),
        .out_valid (v_out[gi])
      );

      if (gi == NSEG - 1) begin : g_last
        assign d_wrap[gi*SEG +: SEG] = sum_seg[gi];
      end else begin : g_deskew
        logic [SEG-1:0] s_sk_reg [NSEG-1-gi];

        // Hold finished low segments until the top segment completes.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < NSEG - 1 - gi; i++) begin
              s_sk_reg[i] <= '0;
            end
          end else if (advance) begin
            s_sk_reg[0] <= sum_seg[gi];
            for (int i = 1; i < NSEG - 1 - gi; i++) begin
              s_sk_reg[i] <= s_sk_reg[i-1];
            end
          end
        end

        assign d_wrap[gi*SEG +: SEG] = s_sk_reg[NSEG-2-gi];
      end
    end
  endgenerate

  // Capture operand sign bits alongside the top segment for the overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      y_msb_reg <= 1'b0;
    end else if (advance) begin
      a_msb_reg <= a_use[NSEG-1][SEG-1];
      y_msb_reg <= y_use[NSEG-1][SEG-1];
    end
  end

  assign out_valid = v_out[NSEG-1];
  assign cout      = c_out[NSEG-1];
  assign ovf       = (a_msb_reg == y_msb_reg) && (d_wrap[WIDTH-1] != a_msb_reg);

`ifdef ARITH_PIPE_SAT_EN
  // Clamp to the signed limit on the side of the first operand's sign.
  assign d = !ovf ? d_wrap :
             (a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign d = d_wrap;
`endif

endmodule

// File: tb/tb_arith_pipe.sv
// Self-checking bench for arith_pipe: directed vectors, backpressure pattern,
// mid-flight reset and a randomized sweep against a behavioural model.
module tb_arith_pipe;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = 4;

`ifdef ARITH_PIPE_SAT_EN
  localparam logic [15:0] OVF_D = 16'h7FFF;
`else
  localparam logic [15:0] OVF_D = 16'h8000;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [1:0]        sel;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  d;
  logic              cout;
  logic              ovf;

  int total  = 0;
  int passed = 0;

  logic [17:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out   = '0;

  arith_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
  endtask

  // Reference: returns {ovf, cout, d} straight from the arithmetic definition.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [1:0] ms, input logic mc);
    logic [15:0] my;
    logic [16:0] full;
    logic        mo;
    logic [15:0] md;
    case (ms)
      2'd0:    my = mb;
      2'd1:    my = ~mb;
      2'd2:    my = 16'h0000;
      default: my = 16'hFFFF;
    endcase
    full = {1'b0, ma} + {1'b0, my} + {16'b0, mc};
    mo   = (ma[15] == my[15]) && (full[15] != ma[15]);
    md   = full[15:0];
`ifdef ARITH_PIPE_SAT_EN
    if (mo) md = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {mo, full[16], md};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Compare process: checks outputs every cycle against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      chk("reset_outputs", {13'b0, out_valid, ovf, cout, d}, 32'h0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (prev_stall)
        chk("hold_stable", {13'b0, out_valid, ovf, cout, d}, {13'b0, 1'b1, prev_out});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("result_pending", 32'(exp_q.size()), 32'h1);
        end else begin
          chk("result", {14'b0, ovf, cout, d}, {14'b0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, cout, d};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sel, cin));
    end
  end

  // One isolated operation with exact latency and literal result check.
  task automatic send_check(input string name, input logic [15:0] ta, input logic [15:0] tb,
                            input logic [1:0] ts, input logic tc, input logic [17:0] expv);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1; a = ta; b = tb; sel = ts; cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(NSEG));
    chk(name, {14'b0, ovf, cout, d}, {14'b0, expv});
  endtask

  // Streams n operations; rnd selects random valid/ready, else ready 1,0,0,1.
  task automatic stream(input int n, input bit rnd);
    int sent = 0;
    int cyc  = 0;
    bit pending = 1'b0;
    while (sent < n && cyc < 60000) begin
      @(posedge clk); #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (!pending) begin
        in_valid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
        a   = pick16();
        b   = pick16();
        sel = 2'($urandom);
        cin = 1'($urandom);
      end
      #1;
      pending = in_valid && !in_ready;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'(n));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = '0; cin = 1'b0;

    // Pin the model to hand-computed values.
    chk("model_add",  {14'b0, model(16'h1234, 16'h1111, 2'b00, 1'b0)}, {14'b0, 2'b00, 16'h2345});
    chk("model_sub",  {14'b0, model(16'h0005, 16'h0003, 2'b01, 1'b1)}, {14'b0, 2'b01, 16'h0002});
    chk("model_ovf",  {14'b0, model(16'h7FFF, 16'h0001, 2'b00, 1'b0)}, {14'b0, 2'b10, OVF_D});
    chk("model_ones", {14'b0, model(16'hFFFF, 16'h0000, 2'b11, 1'b0)}, {14'b0, 2'b01, 16'hFFFE});
    chk("model_zero", {14'b0, model(16'hABCD, 16'h5555, 2'b10, 1'b1)}, {14'b0, 2'b00, 16'hABCE});

    repeat (2) @(posedge clk);
    #1;
    chk("in_ready_during_reset", {31'b0, in_ready}, 32'h1);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'h1);
    chk("out_valid_after_reset", {31'b0, out_valid}, 32'h0);

    send_check("add",  16'h1234, 16'h1111, 2'b00, 1'b0, {2'b00, 16'h2345});
    send_check("sub",  16'h0005, 16'h0003, 2'b01, 1'b1, {2'b01, 16'h0002});
    send_check("ovf",  16'h7FFF, 16'h0001, 2'b00, 1'b0, {2'b10, OVF_D});
    send_check("ones", 16'hFFFF, 16'h0000, 2'b11, 1'b0, {2'b01, 16'hFFFE});
    send_check("zero", 16'hABCD, 16'h5555, 2'b10, 1'b1, {2'b00, 16'hABCE});

    // Eight back-to-back operations under the 1,0,0,1 ready pattern.
    stream(8, 1'b0);

    // Fill the pipe so a result is showing, then reset mid-flight.
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'(16'h0100 * (i + 1)); b = 16'h0011; sel = 2'b00; cin = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("reset_clears_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_in_ready_now", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_after_reset", {31'b0, out_valid}, 32'h0);
    end
    send_check("post_reset", 16'h00F0, 16'h000F, 2'b00, 1'b1, {2'b00, 16'h0100});

    // Randomized sweep with random valid/ready.
    stream(10000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
